dm_arbiter: RTL and testbench

Arbitrates single-ported data memory between the pipeline MEM stage (CPU port) and a DMA/context-save master (DMA port). Drives DM address, byte-enable, unsigned flag, write data, read strobe and write strobe. Registers read data back to the winning requester. Supports DMA bursts, DMA starvation protection and byte-enable legality checking.

---
 rtl/dm_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a DMA/context-save master.
// Optional round-robin tie-break when DM_ARB_RR_EN is defined; default is fixed CPU priority.
module dm_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [29:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_u,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [29:0] dma_addr,
  input  logic [3:0]  dma_be,
  input  logic        dma_u,
  input  logic [31:0] dma_wdata,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic        dm_u,
  output logic [31:0] dm_din,
  output logic        dm_read,
  output logic        dm_wr,
  input  logic [31:0] dm_dout,
  output logic        err
);

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  typedef enum logic {ARB, DMA_OWN} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  beat_cnt;
  logic        last_dma;
  logic        cpu_prio;

  logic        cpu_win, dma_win, any_gnt;
  logic        win_wr, be_ok;
  logic [3:0]  win_be;
  logic [31:0] rd_word;

  // Grants are gated by reset so an asserted reset kills any in-flight access at once.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (rst) begin
      if (state == DMA_OWN) begin
        dma_win = dma_req;
        cpu_win = cpu_req & ~dma_req;
      end else if (cpu_req && dma_req) begin
        if (cpu_prio) begin
          cpu_win = 1'b1;
        end else if (wait_cnt >= MAX_WAIT_C) begin
          dma_win = 1'b1;
        end else begin
`ifdef DM_ARB_RR_EN
          dma_win = ~last_dma;
          cpu_win = last_dma;
`else
          cpu_win = 1'b1;
`endif
        end
      end else begin
        cpu_win = cpu_req;
        dma_win = dma_req;
      end
    end
  end

  assign any_gnt   = cpu_win | dma_win;
  assign cpu_gnt   = cpu_win;
  assign dma_gnt   = dma_win;
  assign cpu_stall = cpu_req & ~cpu_win;

  assign win_wr = dma_win ? dma_wr : cpu_wr;
  assign win_be = dma_win ? dma_be : cpu_be;

  always_comb begin
    case (win_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  assign dm_addr = !any_gnt ? '0 : (dma_win ? dma_addr  : cpu_addr);
  assign dm_din  = !any_gnt ? '0 : (dma_win ? dma_wdata : cpu_wdata);
  assign dm_u    = any_gnt & (dma_win ? dma_u : cpu_u);
  assign dm_be   = any_gnt ? win_be : '0;
  assign dm_read = any_gnt & be_ok & ~win_wr;
  assign dm_wr   = any_gnt & be_ok & win_wr;

  assign rd_word = be_ok ? dm_dout : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      last_dma   <= 1'b0;
      cpu_prio   <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      err        <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_win & ~cpu_wr;
      dma_rvalid <= dma_win & ~dma_wr;
      if (cpu_win && !cpu_wr) cpu_rdata <= rd_word;
      if (dma_win && !dma_wr) dma_rdata <= rd_word;
      err <= any_gnt & ~be_ok;
      if (any_gnt) last_dma <= dma_win;

      if (dma_win)
        wait_cnt <= '0;
      else if (dma_req && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;

      // cpu_prio lives for exactly one ARB cycle after a forced release.
      case (state)
        ARB: begin
          cpu_prio <= 1'b0;
          if (dma_win && !dma_last) begin
            if (BURST_MAX_C <= 8'd1) begin
              cpu_prio <= 1'b1;
            end else begin
              state    <= DMA_OWN;
              beat_cnt <= 8'd1;
            end
          end
        end
        DMA_OWN: begin
          if (!dma_req || dma_last) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else if (beat_cnt + 8'd1 >= BURST_MAX_C) begin
            state    <= ARB;
            beat_cnt <= '0;
            cpu_prio <= 1'b1;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter (default build) with a small byte-enabled DM model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_u = 1'b0;
  logic [29:0] cpu_addr = '0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_wr = 1'b0, dma_u = 1'b0, dma_last = 1'b0;
  logic [29:0] dma_addr = '0;
  logic [3:0]  dma_be = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [29:0] dm_addr;
  logic [3:0]  dm_be;
  logic        dm_u, dm_read, dm_wr, err;
  logic [31:0] dm_din, dm_dout;

  logic [31:0] mem [0:63];
  logic        mem_load = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_WAIT(8), .BURST_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_u(cpu_u), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_be(dma_be),
    .dma_u(dma_u), .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_u(dm_u), .dm_din(dm_din),
    .dm_read(dm_read), .dm_wr(dm_wr), .dm_dout(dm_dout), .err(err)
  );

  assign dm_dout = mem[dm_addr[5:0]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[5] <= 32'hDEADBEEF;
      mem[6] <= 32'h11112222;
    end else if (dm_wr) begin
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr[5:0]][b*8 +: 8] <= dm_din[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and DM preload
    tick();
    tick();
    mem_load = 1'b0;
    #1;
    chk("rst_cpu_gnt",    cpu_gnt,    0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
    chk("rst_err",        err,        0);
    chk("rst_cpu_rdata",  cpu_rdata,  0);
    chk("rst_dma_rdata",  dma_rdata,  0);
    chk("rst_dm_read",    dm_read,    0);
    rst = 1'b1;
    tick();

    // CPU-only read of word 5
    cpu_req = 1; cpu_wr = 0; cpu_addr = 30'd5; cpu_be = 4'hF;
    #1;
    chk("rd_cpu_gnt", cpu_gnt,  1);
    chk("rd_dm_read", dm_read,  1);
    chk("rd_dm_wr",   dm_wr,    0);
    chk("rd_dm_addr", dm_addr,  5);
    chk("rd_stall",   cpu_stall, 0);
    tick();
    cpu_req = 0;
    #1;
    chk("rd_rvalid", cpu_rvalid, 1);
    chk("rd_rdata",  cpu_rdata,  32'hDEADBEEF);
    chk("idle_dm_addr", dm_addr, 0);
    tick();
    chk("rd_rvalid_pulse", cpu_rvalid, 0);

    // contention: CPU wins 8 cycles, DMA wins the 9th
    cpu_req = 1; cpu_addr = 30'd5;
    dma_req = 1; dma_wr = 0; dma_addr = 30'd6; dma_be = 4'hF; dma_last = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("cont_cpu_gnt", cpu_gnt, 1);
      chk("cont_dma_gnt", dma_gnt, 0);
      tick();
    end
    #1;
    chk("starve_dma_gnt", dma_gnt,   1);
    chk("starve_cpu_gnt", cpu_gnt,   0);
    chk("starve_stall",   cpu_stall, 1);
    chk("starve_dm_addr", dm_addr,   6);
    tick();
    chk("starve_dma_rvalid", dma_rvalid, 1);
    chk("starve_dma_rdata",  dma_rdata,  32'h11112222);
    chk("after_starve_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 0; dma_req = 0;
    tick();

    // 4-beat DMA write burst with CPU waiting
    for (int i = 0; i < 4; i++) begin
      dma_req = 1; dma_wr = 1; dma_addr = 30'(10 + i); dma_be = 4'hF;
      dma_wdata = 32'hA0 + 32'(i); dma_last = (i == 3);
      cpu_req = (i != 0); cpu_wr = 0; cpu_addr = 30'd5;
      #1;
      chk("b4_dma_gnt", dma_gnt, 1);
      chk("b4_dm_wr",   dm_wr,   1);
      chk("b4_cpu_gnt", cpu_gnt, 0);
      if (i != 0) chk("b4_stall", cpu_stall, 1);
      tick();
    end
    dma_req = 0; dma_last = 0;
    #1;
    chk("b4_cpu_after", cpu_gnt, 1);
    chk("b4_mem13",     mem[13], 32'hA3);
    tick();
    cpu_req = 0;
    chk("b4_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();

    // endless DMA burst: forced release after beat 16
    for (int i = 0; i < 16; i++) begin
      dma_req = 1; dma_wr = 1; dma_addr = 30'(20 + i); dma_be = 4'hF;
      dma_wdata = 32'hB0 + 32'(i); dma_last = 0;
      cpu_req = (i != 0);
      #1;
      chk("b16_dma_gnt", dma_gnt, 1);
      tick();
    end
    dma_addr = 30'd36; dma_wdata = 32'hBF0;
    #1;
    chk("rel_cpu_gnt", cpu_gnt, 1);
    chk("rel_dma_gnt", dma_gnt, 0);
    chk("rel_mem35",   mem[35], 32'hBF);
    chk("rel_mem36",   mem[36], 0);
    tick();
    cpu_req = 0; dma_last = 1;
    #1;
    chk("resume_dma_gnt", dma_gnt, 1);
    tick();
    dma_req = 0; dma_last = 0;
    chk("resume_mem36", mem[36], 32'hBF0);

    // illegal byte enables
    cpu_req = 1; cpu_wr = 1; cpu_addr = 30'd5; cpu_be = 4'b0101; cpu_wdata = 32'h12345678;
    #1;
    chk("ill_wr_gnt",   cpu_gnt, 1);
    chk("ill_wr_dm_wr", dm_wr,   0);
    chk("ill_wr_err0",  err,     0);
    tick();
    cpu_req = 0;
    chk("ill_wr_err",    err,        1);
    chk("ill_wr_rvalid", cpu_rvalid, 0);
    chk("ill_wr_mem5",   mem[5],     32'hDEADBEEF);
    tick();
    chk("ill_err_pulse", err, 0);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 30'd6; cpu_be = 4'b0110;
    #1;
    chk("ill_rd_dm_read", dm_read, 0);
    tick();
    cpu_be = 4'b0011; cpu_u = 1;
    chk("ill_rd_rvalid", cpu_rvalid, 1);
    chk("ill_rd_rdata",  cpu_rdata,  0);
    chk("ill_rd_err",    err,        1);
    #1;
    chk("half_dm_be", dm_be, 4'b0011);
    chk("half_dm_u",  dm_u,  1);
    tick();
    cpu_req = 0; cpu_u = 0; cpu_be = 4'hF;
    chk("half_rdata", cpu_rdata, 32'h11112222);
    chk("half_err",   err,       0);
    tick();

    // reset asserted during beat 3 of a burst
    dma_req = 1; dma_wr = 0; dma_addr = 30'd5; dma_be = 4'hF; dma_last = 0;
    tick();
    chk("mr_b1_rdata", dma_rdata, 32'hDEADBEEF);
    tick();
    dma_wr = 1; dma_addr = 30'd42; dma_wdata = 32'hC2; cpu_req = 1; cpu_addr = 30'd6;
    #1;
    chk("mr_b3_gnt",    dma_gnt,    1);
    chk("mr_b3_rvalid", dma_rvalid, 1);
    rst = 0;
    #1;
    chk("mr_dma_gnt",    dma_gnt,    0);
    chk("mr_cpu_gnt",    cpu_gnt,    0);
    chk("mr_dma_rvalid", dma_rvalid, 0);
    chk("mr_dma_rdata",  dma_rdata,  0);
    chk("mr_dm_wr",      dm_wr,      0);
    chk("mr_err",        err,        0);
    tick();
    chk("mr_mem42", mem[42], 0);
    dma_req = 0;
    rst = 1;
    #1;
    chk("mr_cpu_first", cpu_gnt, 1);
    tick();
    cpu_req = 0;
    chk("mr_cpu_rvalid", cpu_rvalid, 1);
    chk("mr_cpu_rdata",  cpu_rdata,  32'h11112222);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
